// File: rtl/esn_seq_ctrl.sv
// Echo-state-network sequencer: walks reservoir rows, the readout and an optional LMS pass.
// Build macro ESN_TRAIN_EN adds the TRAIN state and drives wupd_en; without it wupd_en is tied 0.
module esn_seq_ctrl #(
    parameter int unsigned N_NEURONS = 8,
    parameter int unsigned IDX_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             mac_clr,
    output logic             mac_en,
    output logic [IDX_W-1:0] row_idx,
    output logic [IDX_W-1:0] col_idx,
    output logic             state_we,
    output logic             est_valid,
    output logic             wupd_en,
    output logic             done
);

    localparam logic [IDX_W-1:0] ROW_LAST     = IDX_W'(N_NEURONS - 1);
    localparam logic [IDX_W-1:0] COL_RES_LAST = IDX_W'(N_NEURONS);
    localparam logic [IDX_W-1:0] COL_OUT_LAST = IDX_W'(N_NEURONS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE      = IDX_W'(1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RES_CLR,
        ST_RES_MAC,
        ST_RES_WB,
        ST_OUT_CLR,
        ST_OUT_MAC,
        ST_OUT_WB,
`ifdef ESN_TRAIN_EN
        ST_TRAIN,
`endif
        ST_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;

    logic             busy_q, busy_d;
    logic             mac_clr_q, mac_clr_d;
    logic             mac_en_q, mac_en_d;
    logic             state_we_q, state_we_d;
    logic             est_valid_q, est_valid_d;
    logic             done_q, done_d;
    logic [IDX_W-1:0] row_idx_q, row_idx_d;
    logic [IDX_W-1:0] col_idx_q, col_idx_d;
`ifdef ESN_TRAIN_EN
    logic             wupd_en_q, wupd_en_d;
`endif

    // Abort only cancels a sample in flight; in IDLE it is ignored.
    logic kill_c;
    assign kill_c = abort && (state_q != ST_IDLE);

    // State, index counters and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            busy_q      <= 1'b0;
            mac_clr_q   <= 1'b0;
            mac_en_q    <= 1'b0;
            state_we_q  <= 1'b0;
            est_valid_q <= 1'b0;
            done_q      <= 1'b0;
            row_idx_q   <= '0;
            col_idx_q   <= '0;
`ifdef ESN_TRAIN_EN
            wupd_en_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            busy_q      <= busy_d;
            mac_clr_q   <= mac_clr_d;
            mac_en_q    <= mac_en_d;
            state_we_q  <= state_we_d;
            est_valid_q <= est_valid_d;
            done_q      <= done_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
`ifdef ESN_TRAIN_EN
            wupd_en_q   <= wupd_en_d;
`endif
        end
    end

    // Next state; every counter is left at 0 when its phase terminates.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        if (kill_c) begin
            state_d = ST_IDLE;
            row_d   = '0;
            col_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    row_d = '0;
                    col_d = '0;
                    if (start) begin
                        state_d = ST_RES_CLR;
                    end
                end
                ST_RES_CLR: begin
                    col_d   = '0;
                    state_d = ST_RES_MAC;
                end
                ST_RES_MAC: begin
                    if (col_q == COL_RES_LAST) begin
                        col_d   = '0;
                        state_d = ST_RES_WB;
                    end else begin
                        col_d = col_q + IDX_ONE;
                    end
                end
                ST_RES_WB: begin
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        state_d = ST_OUT_CLR;
                    end else begin
                        row_d   = row_q + IDX_ONE;
                        state_d = ST_RES_CLR;
                    end
                end
                ST_OUT_CLR: begin
                    col_d   = '0;
                    state_d = ST_OUT_MAC;
                end
                ST_OUT_MAC: begin
                    if (col_q == COL_OUT_LAST) begin
                        col_d   = '0;
                        state_d = ST_OUT_WB;
                    end else begin
                        col_d = col_q + IDX_ONE;
                    end
                end
                ST_OUT_WB: begin
                    col_d = '0;
`ifdef ESN_TRAIN_EN
                    state_d = ST_TRAIN;
`else
                    state_d = ST_DONE;
`endif
                end
`ifdef ESN_TRAIN_EN
                ST_TRAIN: begin
                    if (col_q == COL_OUT_LAST) begin
                        col_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        col_d = col_q + IDX_ONE;
                    end
                end
`endif
                ST_DONE: begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = ST_IDLE;
                end
                default: begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode of the current state; registered, so strobes trail the state by one cycle.
    always_comb begin
        busy_d      = 1'b0;
        mac_clr_d   = 1'b0;
        mac_en_d    = 1'b0;
        state_we_d  = 1'b0;
        est_valid_d = 1'b0;
        done_d      = 1'b0;
        row_idx_d   = '0;
        col_idx_d   = '0;
`ifdef ESN_TRAIN_EN
        wupd_en_d   = 1'b0;
`endif
        if (!kill_c) begin
            busy_d    = (state_q != ST_IDLE);
            row_idx_d = row_q;
            col_idx_d = col_q;
            case (state_q)
                ST_RES_CLR, ST_OUT_CLR: mac_clr_d   = 1'b1;
                ST_RES_MAC, ST_OUT_MAC: mac_en_d    = 1'b1;
                ST_RES_WB:              state_we_d  = 1'b1;
                ST_OUT_WB:              est_valid_d = 1'b1;
`ifdef ESN_TRAIN_EN
                ST_TRAIN:               wupd_en_d   = 1'b1;
`endif
                ST_DONE:                done_d      = 1'b1;
                default:                ;
            endcase
        end
    end

    assign busy      = busy_q;
    assign mac_clr   = mac_clr_q;
    assign mac_en    = mac_en_q;
    assign state_we  = state_we_q;
    assign est_valid = est_valid_q;
    assign done      = done_q;
    assign row_idx   = row_idx_q;
    assign col_idx   = col_idx_q;
`ifdef ESN_TRAIN_EN
    assign wupd_en   = wupd_en_q;
`else
    assign wupd_en   = 1'b0;
`endif

endmodule

// File: tb/tb_esn_seq_ctrl.sv
// Bench for esn_seq_ctrl: directed scenarios plus random start/abort/reset traffic,
// checked every cycle against an offset-within-sample schedule model.
module tb_esn_seq_ctrl;

    localparam int N  = 8;
    localparam int IW = 4;
    localparam int VW = 7 + 2 * IW;
    localparam int R  = N * (N + 3);
`ifdef ESN_TRAIN_EN
    localparam int TRN = 1;
`else
    localparam int TRN = 0;
`endif
    localparam int D        = R + N + 2 + TRN * N;
    localparam int DONE_OFF = D + 1;
    localparam int EST_OFF  = R + N + 2;

    logic          clk, rst, start, abort;
    logic          busy, mac_clr, mac_en, state_we, est_valid, wupd_en, done;
    logic [IW-1:0] row_idx, col_idx;
    logic [VW-1:0] obs, exp_v;

    int total, bad, edge_n, u, s_edge;
    int we_cnt, res_mac_cnt, wupd_cnt, est_cnt, last_est;
    int done_edges[$];

    esn_seq_ctrl #(.N_NEURONS(N), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .mac_clr(mac_clr), .mac_en(mac_en),
        .row_idx(row_idx), .col_idx(col_idx), .state_we(state_we),
        .est_valid(est_valid), .wupd_en(wupd_en), .done(done)
    );

    assign obs = {busy, mac_clr, mac_en, state_we, est_valid, wupd_en, done, row_idx, col_idx};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for a cycle whose state is at offset u in the sample (u<0 = idle).
    function automatic logic [VW-1:0] decode(input int uo);
        logic [6:0] f;
        int row, col;
        f = '0; row = 0; col = 0;
        if (uo >= 0) begin
            f[6] = 1'b1;
            if (uo < R) begin
                row = uo / (N + 3);
                if (uo % (N + 3) == 0) f[5] = 1'b1;
                else if (uo % (N + 3) <= N + 1) begin f[4] = 1'b1; col = uo % (N + 3) - 1; end
                else f[3] = 1'b1;
            end else if (uo == R) f[5] = 1'b1;
            else if (uo <= R + N) begin f[4] = 1'b1; col = uo - R - 1; end
            else if (uo == R + N + 1) f[2] = 1'b1;
            else if (uo < D) begin f[1] = 1'b1; col = uo - R - N - 2; end
            else f[0] = 1'b1;
        end
        return {f, IW'(row), IW'(col)};
    endfunction

    task automatic chk(input string tag, input logic [VW-1:0] o, input logic [VW-1:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s edge=%0d observed=%h expected=%h", tag, edge_n, o, e);
        end
    endtask

    task automatic chk_int(input string tag, input int o, input int e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    // One clock: drive inputs for this cycle, advance the model, compare after the edge.
    task automatic cyc(input logic st, input logic ab);
        start = st;
        abort = ab;
        if (u >= 0 && ab) begin
            exp_v = '0;
            u = -1;
        end else begin
            exp_v = decode(u);
            if (u < 0) begin
                if (st) begin u = 0; s_edge = edge_n + 1; end
            end else if (u == D) u = -1;
            else u = u + 1;
        end
        edge_n++;
        @(negedge clk);
        chk("cycle", obs, exp_v);
        if (done) done_edges.push_back(edge_n);
        if (est_valid) begin est_cnt++; last_est = edge_n; end
        if (mac_en && we_cnt < N) res_mac_cnt++;
        if (state_we) we_cnt++;
        if (wupd_en) wupd_cnt++;
    endtask

    task automatic clear_stats();
        we_cnt = 0; res_mac_cnt = 0; wupd_cnt = 0; est_cnt = 0; last_est = -1;
        done_edges.delete();
    endtask

    // Reset pulse placed strictly between clock edges.
    task automatic rst_mid();
        #1 rst = 1'b1;
        #1 chk("rst_async", obs, '0);
        #1 rst = 1'b0;
        u = -1;
    endtask

    task automatic run_full(input string tag);
        int s;
        clear_stats();
        cyc(1'b1, 1'b0);
        s = s_edge;
        for (int i = 0; i < DONE_OFF + 10; i++) cyc(1'b0, 1'b0);
        chk_int({tag, "_ndone"}, done_edges.size(), 1);
        if (done_edges.size() > 0) chk_int({tag, "_done_at"}, done_edges[0] - s, DONE_OFF);
    endtask

    initial begin
        total = 0; bad = 0; edge_n = 0; u = -1; s_edge = 0;
        clear_stats();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", obs, '0);
        rst = 1'b0;

        // Single sample, with a stray start mid-sample that must be ignored.
        clear_stats();
        cyc(1'b1, 1'b0);
        begin
            int s;
            s = s_edge;
            for (int i = 0; i < 30; i++) cyc(1'b0, 1'b0);
            cyc(1'b1, 1'b0);
            for (int i = 0; i < 80; i++) cyc(1'b0, 1'b0);
            chk_int("est_at", last_est - s, EST_OFF);
            chk_int("n_est", est_cnt, 1);
            chk_int("n_done", done_edges.size(), 1);
            if (done_edges.size() > 0) chk_int("done_at", done_edges[0] - s, DONE_OFF);
            chk_int("n_state_we", we_cnt, N);
            chk_int("n_res_mac", res_mac_cnt, N * (N + 1));
            chk_int("n_wupd", wupd_cnt, TRN * N);
        end

        // Start presented in the DONE cycle, then idle gap afterwards.
        cyc(1'b1, 1'b0);
        begin
            int s;
            s = s_edge;
            while (edge_n < s + D) cyc(1'b0, 1'b0);
            cyc(1'b1, 1'b0);
            chk_int("done_pulse", int'(done), 1);
            cyc(1'b0, 1'b0);
            chk_int("busy_after_done", int'(busy), 0);
            cyc(1'b0, 1'b0);
            chk_int("start_in_done_ignored", int'(busy), 0);
        end

        // Start held high: back-to-back samples.
        clear_stats();
        for (int i = 0; i < 300; i++) cyc(1'b1, 1'b0);
        for (int i = 0; i < 110; i++) cyc(1'b0, 1'b0);
        chk_int("b2b_count", done_edges.size(), 3);
        for (int i = 1; i < done_edges.size(); i++)
            chk_int("b2b_spacing", done_edges[i] - done_edges[i-1], DONE_OFF + 1);

        // Abort during cycle 40 of a sample.
        clear_stats();
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        chk_int("abort_busy", int'(busy), 0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0);
        chk_int("abort_no_done", done_edges.size(), 0);
        chk_int("abort_no_est", est_cnt, 0);
        run_full("after_abort");

        // Reset between edges at cycle 50.
        clear_stats();
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 50; i++) cyc(1'b0, 1'b0);
        rst_mid();
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
        chk_int("rst_no_done", done_edges.size(), 0);
        run_full("after_rst");

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if ($urandom_range(0, 399) == 0) rst_mid();
            cyc(r < 20, r >= 98);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
